boot_sequencer: RTL and testbench

Load-and-release controller for the rv32i single-core datapath. On a start command it accepts a stream of 32-bit words over a valid/ready handshake. It writes the first `d_count` words into data BRAM and the next `i_count` words into instruction BRAM, using 4-byte aligned byte addresses from 0. It then releases the core by deasserting reset/stall and enabling instruction and register reads. It replaces hand-sequenced BRAM initialisation and sits between the host/loader link and the `pc`, `bram32` and `register_file` control inputs.

---
 rtl/boot_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_boot_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : boot_sequencer
// Purpose  : Streams data and instruction words into their BRAMs, then
//            releases the rv32i core from reset/stall.
// Revision : 1.0 - initial release
// ============================================================================

module boot_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 256,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halt,
    input  logic [CNT_WIDTH-1:0]  d_count,
    input  logic [CNT_WIDTH-1:0]  i_count,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic                  d_bram_init_done,
    output logic                  cpu_rst,
    output logic                  pc_stall,
    output logic                  i_r_enb,
    output logic                  rd_enbl,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_D = 3'd1,
        S_LOAD_I = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_MAX  = CNT_WIDTH'(MAX_WORDS);
    localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_ZERO = '0;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_WIDTH-1:0]   r_d_cnt;
    logic [CNT_WIDTH-1:0]   r_i_cnt;
    logic [CNT_WIDTH-1:0]   r_idx;
    logic                   w_start_bad;
    logic                   w_hs;
    logic                   w_last_d;
    logic                   w_last_i;
    logic [ADDR_WIDTH-1:0]  w_addr;

    assign w_start_bad = (d_count > C_MAX) || (i_count > C_MAX);
    // A halted cycle never counts as a handshake, so the offered word is dropped.
    assign w_hs        = s_valid & s_ready & ~halt;
    assign w_last_d    = (r_idx == (r_d_cnt - C_ONE));
    assign w_last_i    = (r_idx == (r_i_cnt - C_ONE));
    assign w_addr      = {r_idx[ADDR_WIDTH-3:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        s_ready          = 1'b0;
        busy             = 1'b0;
        cpu_rst          = 1'b1;
        pc_stall         = 1'b1;
        i_r_enb          = 1'b0;
        rd_enbl          = 1'b0;
        d_bram_init_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !halt && !w_start_bad) begin
                    if (d_count != C_ZERO) begin
                        w_next = S_LOAD_D;
                    end else if (i_count != C_ZERO) begin
                        w_next = S_LOAD_I;
                    end else begin
                        w_next = S_SETTLE;
                    end
                end
            end
            S_LOAD_D: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (halt) begin
                    w_next = S_IDLE;
                end else if (w_hs && w_last_d) begin
                    w_next = (r_i_cnt == C_ZERO) ? S_SETTLE : S_LOAD_I;
                end
            end
            S_LOAD_I: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (halt) begin
                    w_next = S_IDLE;
                end else if (w_hs && w_last_i) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy   = 1'b1;
                w_next = halt ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                cpu_rst          = 1'b0;
                pc_stall         = 1'b0;
                i_r_enb          = 1'b1;
                rd_enbl          = 1'b1;
                d_bram_init_done = 1'b1;
                if (halt) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_cnt  <= '0;
            r_i_cnt  <= '0;
            r_idx    <= '0;
            d_w_addr <= '0;
            d_w_dat  <= '0;
            d_w_enb  <= 1'b0;
            i_w_addr <= '0;
            i_w_dat  <= '0;
            i_w_enb  <= 1'b0;
            err      <= 1'b0;
        end else begin
            d_w_enb <= 1'b0;
            i_w_enb <= 1'b0;
            err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (start && !halt) begin
                        if (w_start_bad) begin
                            err <= 1'b1;
                        end else begin
                            r_d_cnt <= d_count;
                            r_i_cnt <= i_count;
                        end
                    end
                end
                S_LOAD_D: begin
                    if (w_hs) begin
                        d_w_addr <= w_addr;
                        d_w_dat  <= s_data;
                        d_w_enb  <= 1'b1;
                        r_idx    <= w_last_d ? C_ZERO : (r_idx + C_ONE);
                    end
                end
                S_LOAD_I: begin
                    if (w_hs) begin
                        i_w_addr <= w_addr;
                        i_w_dat  <= s_data;
                        i_w_enb  <= 1'b1;
                        r_idx    <= w_last_i ? C_ZERO : (r_idx + C_ONE);
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_sequencer
// Purpose  : Randomized load/release bench for boot_sequencer against an
//            ordered expected-write model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_boot_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [8:0]  d_count = '0;
    logic [8:0]  i_count = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [9:0]  d_w_addr;
    logic [31:0] d_w_dat;
    logic        d_w_enb;
    logic [9:0]  i_w_addr;
    logic [31:0] i_w_dat;
    logic        i_w_enb;
    logic        d_bram_init_done;
    logic        cpu_rst;
    logic        pc_stall;
    logic        i_r_enb;
    logic        rd_enbl;
    logic        busy;
    logic        err;

    boot_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .halt             (halt),
        .d_count          (d_count),
        .i_count          (i_count),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .d_w_addr         (d_w_addr),
        .d_w_dat          (d_w_dat),
        .d_w_enb          (d_w_enb),
        .i_w_addr         (i_w_addr),
        .i_w_dat          (i_w_dat),
        .i_w_enb          (i_w_enb),
        .d_bram_init_done (d_bram_init_done),
        .cpu_rst          (cpu_rst),
        .pc_stall         (pc_stall),
        .i_r_enb          (i_r_enb),
        .rd_enbl          (rd_enbl),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          side;   // 0: data BRAM, 1: instruction BRAM
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t wlog[$];
    int  err_cycles = 0;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Each enable-high cycle is one BRAM write; log it mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (d_w_enb) wlog.push_back('{side: 1'b0, addr: d_w_addr, data: d_w_dat});
            if (i_w_enb) wlog.push_back('{side: 1'b1, addr: i_w_addr, data: i_w_dat});
            if (err) err_cycles = err_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected: the first d words go to data addresses 0,4,8..., the next i
    // words to instruction addresses 0,4,8..., one write each, in order.
    task automatic load_run(input int d, input int i, input int mode, input int halt_at,
                            input string tag);
        logic [31:0] words[$];
        int k, base, budget, last_cyc, c_now, n, nd, ni;
        bit acc;
        words.delete();
        for (int w = 0; w < d + i; w++) words.push_back($urandom);
        base = wlog.size();

        @(negedge clk);
        start = 1'b1; d_count = 9'(d); i_count = 9'(i);
        last_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0; budget = 0;
        while (k < d + i && budget < 8 * (d + i) + 20) begin
            c_now  = cyc;
            s_data = words[k];
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = cyc[0];
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            if (k == halt_at) begin
                halt = 1'b1; s_valid = 1'b1;
            end
            #1;
            acc = s_valid && s_ready;
            @(negedge clk);
            halt = 1'b0;
            if (k == halt_at) break;
            if (acc) begin
                k++;
                last_cyc = c_now;
            end
            budget++;
        end
        s_valid = 1'b0;

        if (halt_at >= 0) begin
            check({tag, " halt busy"}, busy, 1'b0);
            check({tag, " halt s_ready"}, s_ready, 1'b0);
            check({tag, " halt cpu_rst"}, cpu_rst, 1'b1);
            repeat (3) @(negedge clk);
            nd = 0; ni = 0;
            for (int e = base; e < wlog.size(); e++) begin
                if (wlog[e].side) ni++;
                else begin
                    if (nd < d)
                        check({tag, " halt dwrite"}, {22'd0, wlog[e].addr, wlog[e].data},
                              {22'd0, 10'(nd * 4), words[nd]});
                    nd++;
                end
            end
            check({tag, " halt d writes"}, nd, halt_at);
            check({tag, " halt i writes"}, ni, 0);
        end else begin
            check({tag, " accepted"}, k, d + i);
            check({tag, " settle s_ready"}, s_ready, 1'b0);
            check({tag, " settle busy/cpu_rst"}, {busy, cpu_rst}, 2'b11);
            n = 0;
            while (cpu_rst === 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check({tag, " run latency"}, cyc - last_cyc, 2);
            check({tag, " run outputs"},
                  {cpu_rst, pc_stall, i_r_enb, rd_enbl, d_bram_init_done, busy, s_ready},
                  7'b0011100);
            nd = 0; ni = 0;
            for (int e = base; e < wlog.size(); e++) begin
                if (!wlog[e].side) begin
                    if (nd < d)
                        check({tag, " dwrite"}, {22'd0, wlog[e].addr, wlog[e].data},
                              {22'd0, 10'(nd * 4), words[nd]});
                    nd++;
                end else begin
                    if (ni < i)
                        check({tag, " iwrite"}, {22'd0, wlog[e].addr, wlog[e].data},
                              {22'd0, 10'(ni * 4), words[d + ni]});
                    ni++;
                end
            end
            check({tag, " d writes"}, nd, d);
            check({tag, " i writes"}, ni, i);
            halt = 1'b1;
            @(negedge clk);
            halt = 1'b0;
            check({tag, " post-halt"}, {cpu_rst, pc_stall, busy, d_bram_init_done}, 4'b1100);
        end
    endtask

    initial begin
        int e0;
        repeat (3) @(negedge clk);
        check("reset ctrl", {cpu_rst, pc_stall, i_r_enb, rd_enbl, d_bram_init_done}, 5'b11000);
        check("reset hs", {s_ready, busy, err, d_w_enb, i_w_enb}, 5'b00000);
        check("reset addr/dat", {d_w_addr, i_w_addr, d_w_dat[21:0]}, 42'd0);
        rst = 1'b0;
        @(negedge clk);

        load_run(2, 7, 0, -1, "b2b");
        load_run(2, 7, 1, -1, "toggle");
        load_run(0, 0, 0, -1, "empty");
        load_run(0, 5, 2, -1, "ionly");
        load_run(3, 0, 2, -1, "donly");
        load_run(256, 1, 0, -1, "maxd");
        for (int r = 0; r < 4; r++)
            load_run($urandom_range(0, 12), $urandom_range(0, 12), 2, -1, "rand");

        // Rejected starts
        e0 = err_cycles;
        @(negedge clk);
        start = 1'b1; d_count = 9'd3; i_count = 9'd257;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("reject s_ready", {s_ready, busy}, 2'b00);
            @(negedge clk);
        end
        check("reject err cycles", err_cycles - e0, 1);
        e0 = err_cycles;
        start = 1'b1; d_count = 9'd300; i_count = 9'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reject d err cycles", err_cycles - e0, 1);
        check("reject d state", busy, 1'b0);

        // halt beats start in IDLE
        e0 = err_cycles;
        start = 1'b1; halt = 1'b1; d_count = 9'd2; i_count = 9'd2;
        @(negedge clk);
        start = 1'b0; halt = 1'b0;
        @(negedge clk);
        check("halt+start idle", {busy, s_ready}, 2'b00);
        check("halt+start err", err_cycles - e0, 0);

        // halt on the third data word, then reload from address 0
        load_run(5, 3, 0, 2, "haltd");
        load_run(5, 3, 0, -1, "reload");

        // asynchronous reset in the middle of LOAD_I
        @(negedge clk);
        start = 1'b1; d_count = 9'd2; i_count = 9'd7;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1;
        repeat (4) begin
            s_data = $urandom;
            @(negedge clk);
        end
        check("pre-rst in load_i", {s_ready, busy, i_w_enb}, 3'b111);
        #2 rst = 1'b1;
        #1;
        check("mid rst ctrl", {cpu_rst, pc_stall, i_r_enb, rd_enbl, d_bram_init_done}, 5'b11000);
        check("mid rst hs", {s_ready, busy, err, d_w_enb, i_w_enb}, 5'b00000);
        check("mid rst i bus", {i_w_addr, i_w_dat}, 42'd0);
        check("mid rst d bus", {d_w_addr, d_w_dat}, 42'd0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
